conv2d3x3_multich_featuremap: RTL and testbench
===============================================

// Module: conv2d3x3_multich_featuremap
// PURPOSE
//  Next-generation single-featuremap engine for the YOLOv3Tiny layers.
//  - Takes N_CH input channels in raster order, one pixel per beat.
//  - Applies a 3x3 kernel per channel with valid padding.
//  - Sums across all channels and adds a bias.
//  - Optionally applies leaky ReLU, then saturates.
//  - Kernel weights and bias are runtime-loadable registers, not elaboration constants.
//  - Signed fixed-point arithmetic throughout.
// PARAMETERS
//  DATA_WIDTH  16   signed fixed-point width of pixels, weights, bias and output
//  FRAC_BITS   8    fractional bits of the fixed-point format (Q7.8 at default)
//  N_CH        3    number of input channels
//  IMG_SIZE    416  square input image side, in pixels
//  ACC_WIDTH   40   accumulator width; must be >= 2*DATA_WIDTH+clog2(9*N_CH+1)
//  LEAKY_EN    1    1 = leaky ReLU (negative value >>> 3, slope 0.125); 0 = linear
// PORTS
//  Clk         in   1                  clock; all logic on its rising edge
//  Rst         in   1                  synchronous, active-high reset
//  data_in     in   N_CH*DATA_WIDTH    channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
//  valid_in    in   1                  data_in beat valid; no backpressure
//  w_load      in   1                  write w_data into coefficient register w_addr
//  w_addr      in   clog2(9*N_CH+1)    0..9*N_CH-1: weight ch*9+tap; 9*N_CH: bias
//  w_data      in   DATA_WIDTH         coefficient value (same Q format)
//  data_out    out  DATA_WIDTH         featuremap pixel
//  valid_out   out  1                  data_out valid (single-cycle qualifier)
//  frame_done  out  1                  pulses with the last valid_out of a frame
// BEHAVIOUR
//  - Reset:
//    - col/row counters = 0; valid pipeline cleared.
//    - All coefficient registers = 0.
//    - data_out = 0, valid_out = 0, frame_done = 0.
//    - Line buffers are not cleared.
//  - Input scan: each valid_in beat is pixel (row,col).
//    - col increments; at IMG_SIZE-1 it wraps to 0 and row increments.
//    - After (IMG_SIZE-1, IMG_SIZE-1) both counters wrap to 0; the next beat starts a new frame.
//    - valid_in low leaves counters, line buffers and window unchanged.
//  - Buffering: two line buffers per channel, each IMG_SIZE deep.
//    - Per channel, a 3x3 window shift register advances only on valid_in.
//    - Tap order is row-major (tap 0 = oldest row, oldest column; tap 8 = newest pixel).
//  - Output rule: an output is generated only for beats with row>=2 and col>=2.
//    - Yields (IMG_SIZE-2)^2 outputs per frame, in raster order.
//  - Pipeline: free-running 4 stages; bubbles propagate with a valid tag.
//    - S1: window capture.
//    - S2: 9*N_CH signed products (2*DATA_WIDTH each), using coefficients present that cycle.
//    - S3: adder tree plus (bias <<< FRAC_BITS), full precision in ACC_WIDTH.
//    - S4: >>> FRAC_BITS, then leaky ReLU, then saturation.
//    - Latency: valid_out 4 cycles after the qualifying valid_in beat.
//  - Arithmetic:
//    - Shifts are arithmetic (truncate toward -inf).
//    - Leaky is applied before saturation.
//    - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
//  - data_out holds its last value while valid_out is 0.
//  - frame_done is high in the same cycle as valid_out for output (IMG_SIZE-3, IMG_SIZE-3).
//  - Coefficient load:
//    - Write takes effect the next cycle.
//    - Loading while valid_in is active is legal: valid_in is still accepted, and S2 uses whatever is registered.
//    - Intended use is loading between frames.
//    - w_addr > 9*N_CH is ignored.
//  - Reset mid-frame:
//    - Partial frame is discarded; in-flight outputs are dropped.
//    - The next valid_in beat is pixel (0,0).
//    - Stale line-buffer data is never emitted, because rows 0-1 produce no output.
//  - Back-to-back frames need no gap.
//    - The first two rows of the new frame produce no output; the window never mixes frames into an emitted result.
// TESTING (IMG_SIZE=5, N_CH=2, defaults otherwise)
//  1. All 18 weights 256 (1.0), bias 0, 25 beats of 256
//     -> 9 outputs of 4608 (18.0); first output 4 cycles after beat (2,2); frame_done with 9th.
//  2. All weights -256, inputs 256, LEAKY_EN=1 -> every output -576 (-18.0>>>3).
//     With LEAKY_EN=0 -> -4608.
//  3. Weights 256, inputs 25600 (100.0) -> output saturates to 32767.
//     Weights -256 with LEAKY_EN=0 -> -32768.
//  4. Test 1 with valid_in randomly low ~50% -> identical 9 values in order; exactly one frame_done.
//  5. Rst after 12 beats, then a full frame of test 1 -> exactly 9 outputs of 4608; no output from the aborted frame.
//  6. Test 1 with bias (addr 18) = 128, then a second frame back-to-back with ch1 weights reloaded to 0 before it
//     -> frame 1: 4736; frame 2: 2432.

Source files
------------

// File: rtl/conv2d3x3_multich_featuremap_if.sv
// Bus bundle for the multi-channel 3x3 convolution featuremap engine:
// pixel stream in, coefficient write port, featuremap pixel stream out.
interface conv2d3x3_multich_featuremap_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N_CH       = 3,
    parameter int ADDR_W     = $clog2(9*N_CH+1)
);
    logic [N_CH*DATA_WIDTH-1:0]    data_in;
    logic                          valid_in;
    logic                          w_load;
    logic [ADDR_W-1:0]             w_addr;
    logic signed [DATA_WIDTH-1:0]  w_data;
    logic signed [DATA_WIDTH-1:0]  data_out;
    logic                          valid_out;
    logic                          frame_done;

    modport master (
        output data_in, valid_in, w_load, w_addr, w_data,
        input  data_out, valid_out, frame_done
    );

    modport slave (
        input  data_in, valid_in, w_load, w_addr, w_data,
        output data_out, valid_out, frame_done
    );
endinterface

// File: rtl/conv2d3x3_multich_featuremap.sv
// Single-featuremap 3x3 convolution engine (valid padding) over N_CH raster
// channels. Per-channel line buffers feed a 3x3 window; 9*N_CH products are
// summed with a runtime bias, shifted back to the pixel format, passed
// through an optional leaky ReLU and saturated. Four-stage pipeline with a
// valid tag; coefficients live in writable registers.
module conv2d3x3_multich_featuremap #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int N_CH       = 3,
    parameter int IMG_SIZE   = 416,
    parameter int ACC_WIDTH  = 40,
    parameter int LEAKY_EN   = 1
) (
    input logic                             Clk,
    input logic                             Rst,
    conv2d3x3_multich_featuremap_if.slave   bus
);

    localparam int NTAP   = 9*N_CH;
    localparam int ADDR_W = $clog2(NTAP+1);
    localparam int CNT_W  = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 2;
    localparam int PROD_W = 2*DATA_WIDTH;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_SIZE-1);
    localparam logic [CNT_W-1:0] FIRST_OUT_IDX = CNT_W'(2);
    localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(NTAP);

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = -SAT_HI - ACC_WIDTH'(1);

    // Scan position of the incoming beat
    logic [CNT_W-1:0]             r_col;
    logic [CNT_W-1:0]             r_row;

    // Weights at ch*9+tap, bias at NTAP
    logic signed [DATA_WIDTH-1:0] r_coef [NTAP+1];

    // Line buffers: lb0 holds row-2, lb1 holds row-1 at each column
    logic signed [DATA_WIDTH-1:0] r_lb0 [N_CH][IMG_SIZE];
    logic signed [DATA_WIDTH-1:0] r_lb1 [N_CH][IMG_SIZE];

    logic signed [DATA_WIDTH-1:0] r_win_p1  [N_CH][9];
    logic signed [PROD_W-1:0]     r_prod_p2 [NTAP];
    logic signed [ACC_WIDTH-1:0]  r_acc_p3;

    logic r_vld_p1, r_vld_p2, r_vld_p3;
    logic r_last_p1, r_last_p2, r_last_p3;

    logic signed [DATA_WIDTH-1:0] w_pix [N_CH];
    logic                         w_emit;
    logic                         w_last;
    logic signed [ACC_WIDTH-1:0]  w_sum;

    // Arithmetic shift back to the pixel Q format (truncates toward -inf)
    function automatic logic signed [ACC_WIDTH-1:0] f_descale(
        input logic signed [ACC_WIDTH-1:0] x);
        return x >>> FRAC_BITS;
    endfunction

    // Leaky ReLU with slope 1/8 on negative values, or pass-through
    function automatic logic signed [ACC_WIDTH-1:0] f_leaky(
        input logic signed [ACC_WIDTH-1:0] x);
        if (LEAKY_EN != 0 && x < 0)
            return x >>> 3;
        return x;
    endfunction

    // Clamp to the signed DATA_WIDTH range
    function automatic logic signed [DATA_WIDTH-1:0] f_sat(
        input logic signed [ACC_WIDTH-1:0] x);
        if (x > SAT_HI)
            return DATA_WIDTH'(SAT_HI);
        if (x < SAT_LO)
            return DATA_WIDTH'(SAT_LO);
        return DATA_WIDTH'(x);
    endfunction

    // Split the packed channel bus into signed pixels
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++)
            w_pix[ch] = $signed(bus.data_in[ch*DATA_WIDTH +: DATA_WIDTH]);
    end

    assign w_emit = bus.valid_in && (r_row >= FIRST_OUT_IDX) && (r_col >= FIRST_OUT_IDX);
    assign w_last = (r_row == LAST_IDX) && (r_col == LAST_IDX);

    // Raster counters advance per accepted beat and wrap at frame end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.valid_in) begin
            if (r_col == LAST_IDX) begin
                r_col <= '0;
                r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Coefficient register file; out-of-range addresses are dropped
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i <= NTAP; i++)
                r_coef[i] <= '0;
        end else if (bus.w_load && bus.w_addr <= BIAS_ADDR) begin
            r_coef[bus.w_addr] <= bus.w_data;
        end
    end

    // S1: line buffers rotate and the window shifts in a new column
    always_ff @(posedge Clk) begin
        if (bus.valid_in) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                r_lb0[ch][r_col] <= r_lb1[ch][r_col];
                r_lb1[ch][r_col] <= w_pix[ch];
                for (int r = 0; r < 3; r++) begin
                    r_win_p1[ch][r*3]   <= r_win_p1[ch][r*3+1];
                    r_win_p1[ch][r*3+1] <= r_win_p1[ch][r*3+2];
                end
                r_win_p1[ch][2] <= r_lb0[ch][r_col];
                r_win_p1[ch][5] <= r_lb1[ch][r_col];
                r_win_p1[ch][8] <= w_pix[ch];
            end
        end
    end

    // Valid and end-of-frame tags travelling alongside the data stages
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_last_p2 <= 1'b0;
            r_last_p3 <= 1'b0;
        end else begin
            r_vld_p1  <= w_emit;
            r_last_p1 <= w_emit && w_last;
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
            r_vld_p3  <= r_vld_p2;
            r_last_p3 <= r_last_p2;
        end
    end

    // S2: one full-width signed product per channel tap
    always_ff @(posedge Clk) begin
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int t = 0; t < 9; t++) begin
                r_prod_p2[ch*9+t] <= PROD_W'(r_win_p1[ch][t]) * PROD_W'(r_coef[ch*9+t]);
            end
        end
    end

    // Sum of all products plus bias aligned to the product scale
    always_comb begin
        w_sum = ACC_WIDTH'(r_coef[NTAP]) <<< FRAC_BITS;
        for (int i = 0; i < NTAP; i++)
            w_sum = w_sum + ACC_WIDTH'(r_prod_p2[i]);
    end

    // S3: register the full-precision accumulation
    always_ff @(posedge Clk) begin
        r_acc_p3 <= w_sum;
    end

    // S4: descale, activate, saturate; data_out holds between valid beats
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bus.data_out   <= '0;
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.valid_out  <= r_vld_p3;
            bus.frame_done <= r_vld_p3 && r_last_p3;
            if (r_vld_p3)
                bus.data_out <= f_sat(f_leaky(f_descale(r_acc_p3)));
        end
    end

endmodule

// File: tb/tb_conv2d3x3_multich_featuremap.sv
// Directed bench for conv2d3x3_multich_featuremap at IMG_SIZE=5, N_CH=2.
// Two instances share the stimulus: one with leaky ReLU, one linear.
module tb_conv2d3x3_multich_featuremap;

    localparam int DW   = 16;
    localparam int NCH  = 2;
    localparam int IMG  = 5;
    localparam int AW   = $clog2(9*NCH+1);
    localparam int NOUT = (IMG-2)*(IMG-2);

    logic              Clk = 1'b0;
    logic              Rst;
    logic [NCH*DW-1:0] data_in;
    logic              valid_in;
    logic              w_load;
    logic [AW-1:0]     w_addr;
    logic signed [DW-1:0] w_data;

    conv2d3x3_multich_featuremap_if #(.DATA_WIDTH(DW), .N_CH(NCH)) bus_lk ();
    conv2d3x3_multich_featuremap_if #(.DATA_WIDTH(DW), .N_CH(NCH)) bus_ln ();

    assign bus_lk.data_in  = data_in;
    assign bus_lk.valid_in = valid_in;
    assign bus_lk.w_load   = w_load;
    assign bus_lk.w_addr   = w_addr;
    assign bus_lk.w_data   = w_data;
    assign bus_ln.data_in  = data_in;
    assign bus_ln.valid_in = valid_in;
    assign bus_ln.w_load   = w_load;
    assign bus_ln.w_addr   = w_addr;
    assign bus_ln.w_data   = w_data;

    conv2d3x3_multich_featuremap #(
        .DATA_WIDTH(DW), .FRAC_BITS(8), .N_CH(NCH), .IMG_SIZE(IMG),
        .ACC_WIDTH(40), .LEAKY_EN(1)
    ) u_lk (.Clk(Clk), .Rst(Rst), .bus(bus_lk));

    conv2d3x3_multich_featuremap #(
        .DATA_WIDTH(DW), .FRAC_BITS(8), .N_CH(NCH), .IMG_SIZE(IMG),
        .ACC_WIDTH(40), .LEAKY_EN(0)
    ) u_ln (.Clk(Clk), .Rst(Rst), .bus(bus_ln));

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int q_lk[$];
    int q_ln[$];
    int fd_lk[$];
    int fd_ln[$];
    int first_out_cyc;
    int beat12_cyc;
    int n_chk = 0;
    int n_err = 0;

    // Collect outputs and frame_done positions from both instances
    always @(negedge Clk) begin
        if (bus_lk.valid_out) begin
            q_lk.push_back(int'(bus_lk.data_out));
            if (first_out_cyc < 0) first_out_cyc <= cyc;
        end
        if (bus_ln.valid_out) q_ln.push_back(int'(bus_ln.data_out));
        if (bus_lk.frame_done) fd_lk.push_back(bus_lk.valid_out ? q_lk.size()-1 : -1);
        if (bus_ln.frame_done) fd_ln.push_back(bus_ln.valid_out ? q_ln.size()-1 : -1);
    end

    typedef struct {
        string name;
        int    w;
        int    b;
        int    pix;
        int    exp_lk;
        int    exp_ln;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge Clk);
        w_load = 1'b1;
        w_addr = a[AW-1:0];
        w_data = d[DW-1:0];
    endtask

    task automatic load_coefs(input int w, input int b);
        for (int a = 0; a < 9*NCH; a++) wr(a, w);
        wr(9*NCH, b);
        wr(9*NCH+1, 32767);
        @(negedge Clk);
        w_load = 1'b0;
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        valid_in = 1'b0;
        w_load   = 1'b0;
        repeat (n-1) @(negedge Clk);
    endtask

    task automatic clear_mon();
        q_lk.delete();
        q_ln.delete();
        fd_lk.delete();
        fd_ln.delete();
        first_out_cyc = -1;
    endtask

    task automatic drive_frame(input int pix, input bit gaps, input bit ld_ch1, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 2)) begin
                    @(negedge Clk);
                    valid_in = 1'b0;
                    w_load   = 1'b0;
                end
            end
            @(negedge Clk);
            valid_in = 1'b1;
            data_in  = {pix[DW-1:0], pix[DW-1:0]};
            if (ld_ch1 && b < 9) begin
                w_load = 1'b1;
                w_addr = AW'(9 + b);
                w_data = '0;
            end else begin
                w_load = 1'b0;
            end
            if (b == 12) beat12_cyc = cyc;
        end
    endtask

    task automatic chk_vals(input string nm, input int lo, input int hi, input int e_lk, input int e_ln);
        for (int k = lo; k <= hi; k++) begin
            chk($sformatf("%s_lk[%0d]", nm, k), (k < q_lk.size()) ? q_lk[k] : 99999, e_lk);
            chk($sformatf("%s_ln[%0d]", nm, k), (k < q_ln.size()) ? q_ln[k] : 99999, e_ln);
        end
    endtask

    task automatic chk_counts(input string nm, input int n_out, input int n_fd);
        chk({nm, "_cnt_lk"}, q_lk.size(), n_out);
        chk({nm, "_cnt_ln"}, q_ln.size(), n_out);
        chk({nm, "_fdn_lk"}, fd_lk.size(), n_fd);
        chk({nm, "_fdn_ln"}, fd_ln.size(), n_fd);
        if (n_fd > 0) begin
            chk({nm, "_fdpos_lk"}, (fd_lk.size() > 0) ? fd_lk[0] : -2, NOUT-1);
            chk({nm, "_fdpos_ln"}, (fd_ln.size() > 0) ? fd_ln[0] : -2, NOUT-1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{"unit",     256,    0,    256,   4608,   4608};
        tbl[1] = '{"neg",     -256,    0,    256,   -576,  -4608};
        tbl[2] = '{"satp",     256,    0,  25600,  32767,  32767};
        tbl[3] = '{"satn",    -256,    0,  25600, -32768, -32768};
        tbl[4] = '{"bias",     256,  128,    256,   4736,   4736};
        tbl[5] = '{"biasonly",   0, -256,    256,    -32,   -256};
        tbl[6] = '{"trunc",     -1,    0,      1,     -1,     -1};
        tbl[7] = '{"half",     128,    0,   -256,   -288,  -2304};

        Rst = 1'b1; valid_in = 1'b0; w_load = 1'b0;
        data_in = '0; w_addr = '0; w_data = '0;
        first_out_cyc = -1; beat12_cyc = 0;
        repeat (3) @(negedge Clk);
        chk("rst_data_out", int'(bus_lk.data_out), 0);
        chk("rst_valid_out", int'(bus_lk.valid_out), 0);
        chk("rst_frame_done", int'(bus_lk.frame_done), 0);
        Rst = 1'b0;

        // Table-driven frames: one coefficient set and constant input each
        for (int i = 0; i < 8; i++) begin
            load_coefs(tbl[i].w, tbl[i].b);
            clear_mon();
            drive_frame(tbl[i].pix, 1'b0, 1'b0, IMG*IMG);
            idle(8);
            chk_counts(tbl[i].name, NOUT, 1);
            chk_vals(tbl[i].name, 0, NOUT-1, tbl[i].exp_lk, tbl[i].exp_ln);
            chk({tbl[i].name, "_latency"}, first_out_cyc - beat12_cyc, 4);
            chk({tbl[i].name, "_hold"}, int'(bus_lk.data_out), tbl[i].exp_lk);
            chk({tbl[i].name, "_idle_vld"}, int'(bus_lk.valid_out), 0);
        end

        // Random bubbles on valid_in
        load_coefs(256, 0);
        clear_mon();
        drive_frame(256, 1'b1, 1'b0, IMG*IMG);
        idle(8);
        chk_counts("gaps", NOUT, 1);
        chk_vals("gaps", 0, NOUT-1, 4608, 4608);

        // Reset in mid-frame with qualifying beats still in flight
        clear_mon();
        drive_frame(256, 1'b0, 1'b0, 14);
        @(negedge Clk);
        valid_in = 1'b0;
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        idle(8);
        chk_counts("abort", 0, 0);
        // Coefficients were cleared: a frame now yields zeros
        clear_mon();
        drive_frame(256, 1'b0, 1'b0, IMG*IMG);
        idle(8);
        chk_counts("zero_coef", NOUT, 1);
        chk_vals("zero_coef", 0, NOUT-1, 0, 0);
        load_coefs(256, 0);
        clear_mon();
        drive_frame(256, 1'b0, 1'b0, IMG*IMG);
        idle(8);
        chk_counts("after_rst", NOUT, 1);
        chk_vals("after_rst", 0, NOUT-1, 4608, 4608);

        // Back-to-back frames, ch1 weights zeroed during the second frame's first rows
        load_coefs(256, 128);
        clear_mon();
        drive_frame(256, 1'b0, 1'b0, IMG*IMG);
        drive_frame(256, 1'b0, 1'b1, IMG*IMG);
        idle(10);
        chk("b2b_cnt_lk", q_lk.size(), 2*NOUT);
        chk("b2b_cnt_ln", q_ln.size(), 2*NOUT);
        chk_vals("b2b_f1", 0, NOUT-1, 4736, 4736);
        chk_vals("b2b_f2", NOUT, 2*NOUT-1, 2432, 2432);
        chk("b2b_fdn", fd_lk.size(), 2);
        chk("b2b_fd0", (fd_lk.size() > 0) ? fd_lk[0] : -2, NOUT-1);
        chk("b2b_fd1", (fd_lk.size() > 1) ? fd_lk[1] : -2, 2*NOUT-1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
